// File: rtl/text_console_controller.sv
// text_console_controller
//
// Cursor/console front end for the character-plane text display. It takes
// character IDs over a valid/ready handshake and keeps track of a cursor.
// It handles newline, backspace and clear control codes. It drives the
// character plane's cell-write and scroll-up ports, and blanks the bottom
// row that each scroll exposes.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   reset            synchronous, active-high
//   char_in          incoming character ID or control code
//   char_valid       char_in is valid
//   char_ready       block can accept a character (FSM in IDLE)
//   put_row          character plane write row
//   put_col          character plane write column
//   put_character_id character plane write data
//   we               character plane write strobe, one cell per cycle
//   push_up          one-cycle scroll-up pulse to the character plane
//   cursor_row       current cursor row
//   cursor_col       current cursor column
//   busy             FSM not in IDLE
module text_console_controller #(
    parameter int                         ROW_NUMBER     = 15,
    parameter int                         COL_NUMBER     = 40,
    parameter int                         CHAR_ID_LENGTH = 8,
    parameter int                         ROW_BIT_LEN    = 4,
    parameter int                         COL_BIT_LEN    = 6,
    parameter logic [CHAR_ID_LENGTH-1:0]  BLANK_ID       = '0,
    parameter logic [CHAR_ID_LENGTH-1:0]  CODE_NEWLINE   = 8'h0A,
    parameter logic [CHAR_ID_LENGTH-1:0]  CODE_BACKSPACE = 8'h08,
    parameter logic [CHAR_ID_LENGTH-1:0]  CODE_CLEAR     = 8'h0C
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHAR_ID_LENGTH-1:0] char_in,
    input  logic                      char_valid,
    output logic                      char_ready,
    output logic [ROW_BIT_LEN-1:0]    put_row,
    output logic [COL_BIT_LEN-1:0]    put_col,
    output logic [CHAR_ID_LENGTH-1:0] put_character_id,
    output logic                      we,
    output logic                      push_up,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col,
    output logic                      busy
);

    localparam logic [ROW_BIT_LEN-1:0] LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_SCROLL    = 3'd2;
    localparam logic [2:0] S_BLANK_ROW = 3'd3;
    localparam logic [2:0] S_CLEAR     = 3'd4;

    logic [2:0] state;
    // Set when the current WRITE filled the last cell of the last row.
    logic       scroll_after_write;

    assign char_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

    // The put_* registers also act as the scan counters for CLEAR and
    // BLANK_ROW. A write's address and its sequencing stay aligned, and
    // put_* keep their last value whenever we is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            scroll_after_write <= 1'b0;
            cursor_row         <= '0;
            cursor_col         <= '0;
            put_row            <= '0;
            put_col            <= '0;
            put_character_id   <= '0;
            we                 <= 1'b0;
            push_up            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (char_valid) begin
                        if (char_in == CODE_NEWLINE) begin
                            cursor_col <= '0;
                            if (cursor_row == LAST_ROW) begin
                                push_up <= 1'b1;
                                state   <= S_SCROLL;
                            end else begin
                                cursor_row <= cursor_row + 1'b1;
                            end
                        end else if (char_in == CODE_BACKSPACE) begin
                            if (cursor_col != '0) begin
                                cursor_col         <= cursor_col - 1'b1;
                                put_row            <= cursor_row;
                                put_col            <= cursor_col - 1'b1;
                                put_character_id   <= BLANK_ID;
                                we                 <= 1'b1;
                                scroll_after_write <= 1'b0;
                                state              <= S_WRITE;
                            end else if (cursor_row != '0) begin
                                cursor_row         <= cursor_row - 1'b1;
                                cursor_col         <= LAST_COL;
                                put_row            <= cursor_row - 1'b1;
                                put_col            <= LAST_COL;
                                put_character_id   <= BLANK_ID;
                                we                 <= 1'b1;
                                scroll_after_write <= 1'b0;
                                state              <= S_WRITE;
                            end
                        end else if (char_in == CODE_CLEAR) begin
                            put_row          <= '0;
                            put_col          <= '0;
                            put_character_id <= BLANK_ID;
                            we               <= 1'b1;
                            state            <= S_CLEAR;
                        end else begin
                            put_row          <= cursor_row;
                            put_col          <= cursor_col;
                            put_character_id <= char_in;
                            we               <= 1'b1;
                            state            <= S_WRITE;
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= '0;
                                if (cursor_row == LAST_ROW) begin
                                    scroll_after_write <= 1'b1;
                                end else begin
                                    cursor_row         <= cursor_row + 1'b1;
                                    scroll_after_write <= 1'b0;
                                end
                            end else begin
                                cursor_col         <= cursor_col + 1'b1;
                                scroll_after_write <= 1'b0;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    we <= 1'b0;
                    if (scroll_after_write) begin
                        push_up <= 1'b1;
                        state   <= S_SCROLL;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_SCROLL: begin
                    push_up            <= 1'b0;
                    scroll_after_write <= 1'b0;
                    put_row            <= LAST_ROW;
                    put_col            <= '0;
                    put_character_id   <= BLANK_ID;
                    we                 <= 1'b1;
                    state              <= S_BLANK_ROW;
                end

                S_BLANK_ROW: begin
                    if (put_col == LAST_COL) begin
                        we         <= 1'b0;
                        cursor_row <= LAST_ROW;
                        cursor_col <= '0;
                        state      <= S_IDLE;
                    end else begin
                        put_col <= put_col + 1'b1;
                    end
                end

                S_CLEAR: begin
                    if (put_col == LAST_COL) begin
                        if (put_row == LAST_ROW) begin
                            we         <= 1'b0;
                            cursor_row <= '0;
                            cursor_col <= '0;
                            state      <= S_IDLE;
                        end else begin
                            put_col <= '0;
                            put_row <= put_row + 1'b1;
                        end
                    end else begin
                        put_col <= put_col + 1'b1;
                    end
                end

                default: begin
                    we      <= 1'b0;
                    push_up <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_controller.sv
// tb_text_console_controller
//
// Directed testbench for text_console_controller with the default geometry
// (15 rows x 40 columns). Inputs are driven and outputs are sampled 1ns
// after each rising edge.
module tb_text_console_controller;

    localparam int ROWS = 15;
    localparam int COLS = 40;

    logic       clk;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [3:0] put_row;
    logic [5:0] put_col;
    logic [7:0] put_character_id;
    logic       we;
    logic       push_up;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    int passed = 0;
    int total  = 0;

    text_console_controller #(
        .ROW_NUMBER     (ROWS),
        .COL_NUMBER     (COLS),
        .CHAR_ID_LENGTH (8),
        .ROW_BIT_LEN    (4),
        .COL_BIT_LEN    (6),
        .BLANK_ID       (8'h00),
        .CODE_NEWLINE   (8'h0A),
        .CODE_BACKSPACE (8'h08),
        .CODE_CLEAR     (8'h0C)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .char_in          (char_in),
        .char_valid       (char_valid),
        .char_ready       (char_ready),
        .put_row          (put_row),
        .put_col          (put_col),
        .put_character_id (put_character_id),
        .we               (we),
        .push_up          (push_up),
        .cursor_row       (cursor_row),
        .cursor_col       (cursor_col),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic w, input logic p, input int r, input int c,
                                       input logic [7:0] id);
        logic [3:0] r4;
        logic [5:0] c6;
        r4 = r[3:0];
        c6 = c[5:0];
        return {12'b0, w, p, r4, c6, id};
    endfunction

    function automatic logic [31:0] obs();
        return {12'b0, we, push_up, put_row, put_col, put_character_id};
    endfunction

    function automatic logic [31:0] cur(input int r, input int c);
        logic [3:0] r4;
        logic [5:0] c6;
        r4 = r[3:0];
        c6 = c[5:0];
        return {22'b0, r4, c6};
    endfunction

    function automatic logic [31:0] cur_obs();
        return {22'b0, cursor_row, cursor_col};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!char_ready && n < 1000) begin
            step();
            n++;
        end
        if (!char_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Returns 1ns after the accepting edge, i.e. inside cycle N+1.
    task automatic send(input logic [7:0] ch);
        wait_idle();
        char_in    = ch;
        char_valid = 1'b1;
        step();
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_push_up", {31'b0, push_up}, 32'd0);
        check("rst_cursor", cur_obs(), cur(0, 0));
        check("rst_ready", {31'b0, char_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);

        // First printable character at the home position.
        send(8'h41);
        check("put_A", obs(), mk(1, 0, 0, 0, 8'h41));
        check("put_A_ready", {31'b0, char_ready}, 32'd0);
        check("put_A_cursor", cur_obs(), cur(0, 1));
        step();
        check("put_A_we_drop", {31'b0, we}, 32'd0);

        // 39 more printables wrap onto the next row.
        for (int i = 1; i < COLS; i++) send(8'h41 + 8'(i % 26));
        wait_idle();
        check("wrap_cursor", cur_obs(), cur(1, 0));

        // Move to (3,5), then newline without scroll.
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61);
        wait_idle();
        check("pre_nl_cursor", cur_obs(), cur(3, 5));
        send(8'h0A);
        check("nl_cursor", cur_obs(), cur(4, 0));
        check("nl_no_we", {31'b0, we}, 32'd0);
        check("nl_ready", {31'b0, char_ready}, 32'd1);

        // Move to (14,7), then newline with scroll.
        for (int i = 0; i < 10; i++) send(8'h0A);
        for (int i = 0; i < 7; i++) send(8'h62);
        wait_idle();
        check("pre_scroll_cursor", cur_obs(), cur(14, 7));
        send(8'h0A);
        check("nl_scroll_push", {30'b0, we, push_up}, 32'd1);
        for (int i = 0; i < COLS; i++) begin
            step();
            check("nl_blank", obs(), mk(1, 0, 14, i, 8'h00));
        end
        step();
        check("nl_blank_end_we", {31'b0, we}, 32'd0);
        check("nl_blank_end_ready", {31'b0, char_ready}, 32'd1);
        check("nl_blank_cursor", cur_obs(), cur(14, 0));

        // Fill row 14 to the last cell, then a printable at (14,39) scrolls.
        for (int i = 0; i < COLS - 1; i++) send(8'h30 + 8'(i % 10));
        wait_idle();
        check("pre_last_cursor", cur_obs(), cur(14, 39));
        send(8'h42);
        for (int c = 0; c < COLS + 2; c++) begin
            check("last_busy", {31'b0, busy}, 32'd1);
            if (c == 0) check("last_write", obs(), mk(1, 0, 14, 39, 8'h42));
            else if (c == 1) check("last_push", obs(), mk(0, 1, 14, 39, 8'h42));
            else check("last_blank", obs(), mk(1, 0, 14, c - 2, 8'h00));
            step();
        end
        check("last_busy_end", {31'b0, busy}, 32'd0);
        check("last_we_end", {30'b0, we, push_up}, 32'd0);
        check("last_cursor", cur_obs(), cur(14, 0));

        // Full clear.
        send(8'h0C);
        for (int i = 0; i < ROWS * COLS; i++) begin
            check("clear_cell", obs(), mk(1, 0, i / COLS, i % COLS, 8'h00));
            step();
        end
        check("clear_busy_end", {31'b0, busy}, 32'd0);
        check("clear_we_end", {31'b0, we}, 32'd0);
        check("clear_cursor", cur_obs(), cur(0, 0));

        // Backspace at column 0 of row 2 wraps to the previous row.
        send(8'h0A);
        send(8'h0A);
        check("pre_bs_cursor", cur_obs(), cur(2, 0));
        send(8'h08);
        check("bs_wrap_write", obs(), mk(1, 0, 1, 39, 8'h00));
        check("bs_wrap_cursor", cur_obs(), cur(1, 39));
        step();
        check("bs_wrap_we_drop", {31'b0, we}, 32'd0);

        // Backspace in mid-row.
        send(8'h08);
        check("bs_mid_write", obs(), mk(1, 0, 1, 38, 8'h00));
        check("bs_mid_cursor", cur_obs(), cur(1, 38));

        // Backspace at home is a no-op.
        do_reset();
        send(8'h08);
        check("bs_home_we", {31'b0, we}, 32'd0);
        check("bs_home_busy", {31'b0, busy}, 32'd0);
        check("bs_home_cursor", cur_obs(), cur(0, 0));

        // Reset in the middle of a clear abandons it.
        send(8'h0C);
        for (int i = 0; i < 100; i++) step();
        check("clear100_cell", obs(), mk(1, 0, 2, 20, 8'h00));
        reset = 1'b1;
        step();
        check("rst_clear_out", obs(), mk(0, 0, 0, 0, 8'h00));
        check("rst_clear_cursor", cur_obs(), cur(0, 0));
        check("rst_clear_busy", {31'b0, busy}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rst_clear_ready", {31'b0, char_ready}, 32'd1);
        check("rst_clear_we", {31'b0, we}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/text_console_controller.md
# text_console_controller

Parametrised cursor/console front end for the character-plane text display. It replaces the fixed-pattern character feeder. It accepts a stream of character IDs over a valid/ready handshake and tracks a cursor. It interprets newline, backspace and clear control codes, and drives the character plane's write and scroll ports (`put_row`, `put_col`, `put_character_id`, `we`, `push_up`), blanking the row exposed by each scroll.

## Interface
Parameters:
- ROW_NUMBER, 15, number of text rows
- COL_NUMBER, 40, characters per row
- CHAR_ID_LENGTH, 8, character ID width
- ROW_BIT_LEN, 4, row index width (ceil(log2(ROW_NUMBER)))
- COL_BIT_LEN, 6, column index width (ceil(log2(COL_NUMBER)))
- BLANK_ID, 0, ID written to erase a cell
- CODE_NEWLINE, 8'h0A; CODE_BACKSPACE, 8'h08; CODE_CLEAR, 8'h0C; control codes

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- char_in  in  CHAR_ID_LENGTH  incoming character ID or control code
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept; high exactly when FSM is in IDLE
- put_row  out  ROW_BIT_LEN  write row to character plane
- put_col  out  COL_BIT_LEN  write column to character plane
- put_character_id  out  CHAR_ID_LENGTH  write data to character plane
- we  out  1  write strobe, one cell per cycle
- push_up  out  1  one-cycle scroll-up pulse to character plane
- cursor_row  out  ROW_BIT_LEN  current cursor row
- cursor_col  out  COL_BIT_LEN  current cursor column
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, WRITE, SCROLL, BLANK_ROW, CLEAR.
- Reset: state IDLE, cursor (0,0), `we`=0, `push_up`=0, `put_*`=0. Outputs are registered. `char_ready`=1 from the first cycle after reset is released.
- Transfer occurs on an edge with `char_valid`&&`char_ready`. `char_in` is ignored otherwise.
- Printable code (any non-control value):
  - WRITE cycle: `we`=1 with `put_row`/`put_col` = cursor and `put_character_id`=char.
  - Cursor advances `col+1`.
  - At `col`=COL_NUMBER-1: `col`←0 and `row+1`.
  - At row ROW_NUMBER-1 the row stays and the FSM goes WRITE→SCROLL. Otherwise WRITE→IDLE.
- Newline:
  - Not at last row: `col`←0, `row+1`, applied at the accepting edge; state stays IDLE and no write occurs.
  - At last row: `col`←0, row unchanged, IDLE→SCROLL.
- Backspace:
  - `col`>0: cursor←(row,`col`-1).
  - `col`=0 and `row`>0: cursor←(`row`-1,COL_NUMBER-1).
  - Both cases are followed by WRITE of BLANK_ID at the new cursor position.
  - At (0,0): no-op, state stays IDLE.
- Clear: IDLE→CLEAR. Writes BLANK_ID to every cell in row-major order, one per cycle, from (0,0) to (ROW_NUMBER-1,COL_NUMBER-1). Then cursor←(0,0) and →IDLE.
- SCROLL: exactly one cycle with `push_up`=1 and `we`=0, then →BLANK_ROW.
- BLANK_ROW: COL_NUMBER cycles writing BLANK_ID to row ROW_NUMBER-1, cols 0..COL_NUMBER-1. Then →IDLE with cursor (ROW_NUMBER-1,0).
- `we` and `push_up` are never high in the same cycle.
- `put_*` hold their last value while `we`=0.
- Reset asserted in any state: the next edge forces IDLE and the reset values. No further `we`/`push_up` pulses occur, and any partial clear or blank is abandoned.
- Cursor outputs never exceed ROW_NUMBER-1 / COL_NUMBER-1.

## Timing
- Accept edge N → `we` high during cycle N+1 (printable, backspace). `char_ready` low during N+1. Sustained printable throughput is 1 char per 2 cycles.
- Newline without scroll: no busy cycle; `char_ready` stays high.
- Scroll sequence: 1 push_up cycle + COL_NUMBER blank cycles. A printable char at the last cell gives `busy` for COL_NUMBER+2 cycles.
- Clear: `busy` for ROW_NUMBER*COL_NUMBER cycles.
- `cursor_row`/`cursor_col` reflect the post-command value from the cycle after the accepting edge. For scrolls and clears this value holds from the cycle after the operation completes.

## Test plan
- Reset held 2 cycles, then released → `we`=0, `push_up`=0, cursor (0,0), `char_ready`=1, `busy`=0.
- Send 0x41 at cursor (0,0) → next cycle `we`=1, `put_row`=0, `put_col`=0, `put_character_id`=0x41. Cursor then reads (0,1). After 40 printable chars total, cursor reads (1,0).
- Cursor (3,5), send 0x0A → cursor (4,0), no `we` pulse, `char_ready` never drops. At (14,7), 0x0A → `push_up` pulse, 40 blank writes to row 14, cursor (14,0).
- Cursor (14,39), send 0x42 → write (14,39,0x42). Next cycle `push_up`=1. Then 40 cycles of `we` with `put_row`=14, `put_col` 0..39, id 0. `busy` lasts 42 cycles; final cursor (14,0).
- Backspace at (2,0) → blank write at (1,39), cursor (1,39). Backspace at (0,0) → no `we`, cursor unchanged.
- Send 0x0C → 600 consecutive `we` cycles ending at (14,39), then cursor (0,0). Repeat with reset asserted at clear cycle 100 → `we`=0 from the next cycle, cursor (0,0), `char_ready`=1 after release.
